// File: rtl/spi_shift_master.sv
// SPI mode-0 master: shifts out a {opcode, nbits, pad, op_a} command frame and
// captures the slave's result word during the trailing periods of the same frame.
module spi_shift_master #(
  parameter int REG_WIDTH = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic [4:0]           nbits,
  input  logic [REG_WIDTH-1:0] op_a,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int FRAME_W = REG_WIDTH + 16;
  localparam int NPER    = FRAME_W + REG_WIDTH;
  localparam int BW      = $clog2(NPER);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] PER_LAST = BW'(NPER - 1);
  localparam logic [BW-1:0] RX_FIRST = BW'(FRAME_W);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   half_q, half_d;
  logic [FRAME_W-1:0]     tx_q, tx_d;
  logic [REG_WIDTH-1:0]   rx_q, rx_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [REG_WIDTH-1:0]   result_q, result_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   active_s;

  // Next-state and output computation; pins are registered from the current state,
  // and last_q holds off a new start until the done pulse has been seen.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    half_d   = half_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    last_d   = 1'b0;
    active_s = (state_q == S_SETUP) || (state_q == S_XFER);
    busy_d   = (state_q != S_IDLE);
    done_d   = last_q;
    result_d = last_q ? rx_q : result_q;
    sclk_d   = (state_q == S_XFER) && half_q;
    cs_n_d   = !(active_s || (state_q == S_HOLD));
    mosi_d   = active_s ? tx_q[FRAME_W-1] : 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !last_q && !done_q) begin
          state_d = S_SETUP;
          cnt_d   = 8'd0;
          bit_d   = '0;
          half_d  = 1'b0;
          tx_d    = {opcode, nbits, 7'b0000000, op_a};
          rx_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_XFER;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_XFER: begin
        // first cycle of the high half is the cycle sclk rises on the pin
        if (half_q && (cnt_q == 8'd0) && (bit_q >= RX_FIRST)) begin
          rx_d = {rx_q[REG_WIDTH-2:0], miso};
        end else begin
          rx_d = rx_q;
        end
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
            if (bit_q == PER_LAST) begin
              state_d = S_HOLD;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign sclk   = sclk_q;
  assign cs_n   = cs_n_q;
  assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_shift_master.sv
// Self-checking bench for spi_shift_master: a mode-0 slave model feeds miso and
// records mosi; expected frames, results and edge timings come from plain arithmetic.
module tb_spi_shift_master;

  localparam int DIV  = 2;
  localparam int SDIV = 255;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [4:0]  nbits  = 5'd0;
  logic [31:0] op_a   = 32'd0;
  logic        busy, done, sclk, cs_n, mosi;
  logic [31:0] result;
  logic        miso   = 1'b0;

  logic        start_s = 1'b0;
  logic        busy_s, done_s, sclk_s, cs_n_s, mosi_s;
  logic [31:0] result_s;
  logic        miso_s  = 1'b1;

  int checks = 0;
  int errors = 0;

  spi_shift_master #(.REG_WIDTH(32), .CLK_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .nbits(nbits),
    .op_a(op_a), .busy(busy), .done(done), .result(result), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_shift_master #(.REG_WIDTH(32), .CLK_DIV(SDIV)) dut_slow (
    .clock(clock), .reset(reset), .start(start_s), .opcode(opcode), .nbits(nbits),
    .op_a(op_a), .busy(busy_s), .done(done_s), .result(result_s), .sclk(sclk_s),
    .cs_n(cs_n_s), .mosi(mosi_s), .miso(miso_s)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  // Slave model and bus monitor for the fast instance, evaluated mid-cycle.
  int          period = 0;
  logic [31:0] slave_resp = 32'd0;
  bit          mosi_bits[$];
  int          sclk_rises = 0;
  int          fall_q[$];
  int          rise_q[$];
  int          done_cnt = 0;
  int          mosi_bad = 0;
  int          result_bad = 0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;
  logic [31:0] result_prev = 32'd0;

  always @(negedge clock) begin
    if (cs_prev === 1'b1 && cs_n === 1'b0) begin
      fall_q.push_back(edge_cnt);
      period = 0;
      mosi_bits.delete();
      sclk_rises = 0;
      miso = 1'($urandom);
    end else if (cs_prev === 1'b0 && cs_n === 1'b0 && mosi !== mosi_prev &&
                 !(sclk_prev === 1'b1 && sclk === 1'b0)) begin
      mosi_bad++;
    end
    if (cs_prev === 1'b0 && cs_n === 1'b1) rise_q.push_back(edge_cnt);
    if (sclk_prev === 1'b0 && sclk === 1'b1 && cs_n === 1'b0) begin
      mosi_bits.push_back(mosi);
      sclk_rises++;
    end
    if (sclk_prev === 1'b1 && sclk === 1'b0) begin
      period++;
      // periods 0..47 get junk so the master must discard them
      if (period >= 48 && period < 80) miso = slave_resp[79-period];
      else miso = 1'($urandom);
    end
    if (done === 1'b1) done_cnt++;
    if (result !== result_prev && done !== 1'b1) result_bad++;
    sclk_prev   = sclk;
    cs_prev     = cs_n;
    mosi_prev   = mosi;
    result_prev = result;
  end

  task automatic run_txn(input logic [3:0] op, input logic [4:0] nb, input logic [31:0] a,
                         input logic [31:0] resp, input bit clobber,
                         output int e0, output int done_e);
    @(negedge clock);
    slave_resp = resp;
    opcode = op; nbits = nb; op_a = a; start = 1'b1;
    @(negedge clock);
    e0 = edge_cnt;
    start  = 1'b0;
    opcode = 4'($urandom);
    nbits  = 5'($urandom);
    op_a   = clobber ? 32'hFFFF_FFFF : $urandom;
    done_e = -1;
    for (int i = 0; i < 400 && done_e < 0; i++) begin
      @(negedge clock);
      if (done === 1'b1) done_e = edge_cnt;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_shl_example();
    int e0, de;
    logic [15:0] f16;
    fall_q.delete(); rise_q.delete();
    run_txn(4'b0110, 5'd4, 32'h0000_00FF, 32'h0000_0FF0, 1'b0, e0, de);
    f16 = 16'd0;
    for (int i = 0; i < 16 && i < mosi_bits.size(); i++) f16[15-i] = mosi_bits[i];
    checks++; if (f16 !== 16'h6200) begin errors++; $display("FAIL shl_first16: got %h want 6200", f16); end
    checks++; if (result !== 32'h0000_0FF0) begin errors++; $display("FAIL shl_result: got %h want 00000ff0", result); end
    checks++; if (de - e0 !== 163*DIV+1) begin errors++; $display("FAIL shl_done_edge: got %0d want %0d", de - e0, 163*DIV+1); end
    checks++; if (fall_q.size() !== 1 || rise_q.size() !== 1) begin errors++; $display("FAIL shl_cs_count: got %0d/%0d want 1/1", fall_q.size(), rise_q.size()); end
    checks++; if (fall_q.size() > 0 && fall_q[0] - e0 !== 1) begin errors++; $display("FAIL shl_cs_fall: got %0d want 1", fall_q[0] - e0); end
    checks++; if (rise_q.size() > 0 && rise_q[0] - e0 !== 162*DIV+1) begin errors++; $display("FAIL shl_cs_rise: got %0d want %0d", rise_q[0] - e0, 162*DIV+1); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL shl_done_width: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shl_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_shr_example();
    int e0, de;
    logic [79:0] obs, expv;
    run_txn(4'b0111, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, e0, de);
    obs = 80'd0;
    for (int i = 0; i < 80 && i < mosi_bits.size(); i++) obs[79-i] = mosi_bits[i];
    expv = {4'b0111, 5'd31, 7'd0, 32'h8000_0000, 32'd0};
    checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL shr_result: got %h want 00000001", result); end
    checks++; if (sclk_rises !== 80) begin errors++; $display("FAIL shr_sclk_rises: got %0d want 80", sclk_rises); end
    checks++; if (obs !== expv) begin errors++; $display("FAIL shr_mosi: got %h want %h", obs, expv); end
  endtask

  task automatic test_random();
    int e0, de;
    logic [3:0] op; logic [4:0] nb; logic [31:0] a, resp;
    logic [79:0] obs, expv;
    mosi_bad = 0; result_bad = 0;
    for (int t = 0; t < 5; t++) begin
      case ($urandom_range(0, 2))
        0:       op = 4'b0110;
        1:       op = 4'b0111;
        default: op = 4'($urandom);
      endcase
      nb = 5'($urandom); a = $urandom; resp = $urandom;
      run_txn(op, nb, a, resp, t[0], e0, de);
      obs = 80'd0;
      for (int i = 0; i < 80 && i < mosi_bits.size(); i++) obs[79-i] = mosi_bits[i];
      expv = {op, nb, 7'd0, a, 32'd0};
      checks++; if (obs !== expv) begin errors++; $display("FAIL rand_mosi[%0d]: got %h want %h", t, obs, expv); end
      checks++; if (result !== resp) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", t, result, resp); end
      checks++; if (de - e0 !== 163*DIV+1) begin errors++; $display("FAIL rand_done_edge[%0d]: got %0d want %0d", t, de - e0, 163*DIV+1); end
      checks++; if (sclk_rises !== 80) begin errors++; $display("FAIL rand_sclk_rises[%0d]: got %0d want 80", t, sclk_rises); end
    end
    checks++; if (mosi_bad !== 0) begin errors++; $display("FAIL rand_mosi_edges: got %0d changes off falling edges want 0", mosi_bad); end
    checks++; if (result_bad !== 0) begin errors++; $display("FAIL rand_result_stable: got %0d stray changes want 0", result_bad); end
  endtask

  task automatic test_op_a_change();
    int e0, de;
    logic [79:0] obs;
    run_txn(4'b0110, 5'd9, 32'h1234_5678, 32'hCAFE_F00D, 1'b1, e0, de);
    obs = 80'd0;
    for (int i = 0; i < 80 && i < mosi_bits.size(); i++) obs[79-i] = mosi_bits[i];
    checks++; if (obs[63:32] !== 32'h1234_5678) begin errors++; $display("FAIL opa_change_mosi: got %h want 12345678", obs[63:32]); end
    checks++; if (obs[79:64] !== {4'b0110, 5'd9, 7'd0}) begin errors++; $display("FAIL opa_change_hdr: got %h want %h", obs[79:64], {4'b0110, 5'd9, 7'd0}); end
    checks++; if (result !== 32'hCAFE_F00D) begin errors++; $display("FAIL opa_change_result: got %h want cafef00d", result); end
  endtask

  task automatic test_back_to_back();
    int e0, base, de;
    logic [31:0] resp;
    resp = $urandom;
    fall_q.delete(); rise_q.delete();
    mosi_bad = 0; result_bad = 0;
    base = done_cnt;
    @(negedge clock);
    slave_resp = resp; opcode = 4'($urandom); nbits = 5'($urandom); op_a = $urandom; start = 1'b1;
    @(negedge clock);
    e0 = edge_cnt;
    repeat (499) @(negedge clock);
    start = 1'b0;
    checks++; if (fall_q.size() !== 2) begin errors++; $display("FAIL b2b_txn_count: got %0d want 2", fall_q.size()); end
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - base); end
    if (fall_q.size() >= 2 && rise_q.size() >= 1) begin
      checks++; if (fall_q[1] - e0 !== 163*DIV+4) begin errors++; $display("FAIL b2b_second_accept: got %0d want %0d", fall_q[1] - e0, 163*DIV+4); end
      checks++; if (fall_q[1] - rise_q[0] < 2*DIV) begin errors++; $display("FAIL b2b_gap: got %0d want >= %0d", fall_q[1] - rise_q[0], 2*DIV); end
    end
    de = -1;
    for (int i = 0; i < 400 && de < 0; i++) begin
      @(negedge clock);
      if (done === 1'b1) de = edge_cnt;
    end
    @(negedge clock);
    checks++; if (fall_q.size() < 2 || de - fall_q[1] !== 163*DIV) begin errors++; $display("FAIL b2b_second_done: got done edge %0d want cs fall + %0d", de, 163*DIV); end
    checks++; if (result !== resp) begin errors++; $display("FAIL b2b_result: got %h want %h", result, resp); end
    checks++; if (mosi_bad !== 0 || result_bad !== 0) begin errors++; $display("FAIL b2b_stability: got mosi %0d result %0d want 0/0", mosi_bad, result_bad); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit found;
    base = done_cnt;
    @(negedge clock);
    slave_resp = $urandom; opcode = 4'b0110; nbits = 5'd3; op_a = $urandom; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (period == 60 && cs_n === 1'b0) found = 1'b1;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: got no period 60 want period 60"); end
    checks++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got cs_n %b sclk %b want 1/0", cs_n, sclk); end
    checks++; if (busy !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL rstmid_busy_mosi: got %b/%b want 0/0", busy, mosi); end
    reset = 1'b0;
    repeat (400) @(negedge clock);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - base); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_idle_cs: got %b want 1", cs_n); end
  endtask

  task automatic test_slow_divider();
    int e0, rise_e, fall_e, done_e;
    logic prev;
    @(negedge clock);
    opcode = 4'b0111; nbits = 5'd1; op_a = $urandom; start_s = 1'b1;
    @(negedge clock);
    e0 = edge_cnt; start_s = 1'b0;
    rise_e = -1; fall_e = -1; done_e = -1; prev = 1'b0;
    for (int i = 0; i < 45000 && done_e < 0; i++) begin
      @(negedge clock);
      if (!prev && sclk_s === 1'b1 && rise_e < 0) rise_e = edge_cnt;
      if (prev && sclk_s === 1'b0 && rise_e >= 0 && fall_e < 0) fall_e = edge_cnt;
      prev = sclk_s;
      if (done_s === 1'b1) done_e = edge_cnt;
    end
    @(negedge clock);
    checks++; if (rise_e - e0 !== 2*SDIV+1) begin errors++; $display("FAIL slow_first_rise: got %0d want %0d", rise_e - e0, 2*SDIV+1); end
    checks++; if (fall_e - rise_e !== SDIV) begin errors++; $display("FAIL slow_half_period: got %0d want %0d", fall_e - rise_e, SDIV); end
    checks++; if (done_e - e0 !== 163*SDIV+1) begin errors++; $display("FAIL slow_done_edge: got %0d want %0d", done_e - e0, 163*SDIV+1); end
    checks++; if (result_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL slow_result: got %h want ffffffff", result_s); end
    checks++; if (busy_s !== 1'b0 || cs_n_s !== 1'b1 || mosi_s !== 1'b0) begin errors++; $display("FAIL slow_idle: got busy %b cs_n %b mosi %b want 0/1/0", busy_s, cs_n_s, mosi_s); end
  endtask

  initial begin
    test_reset();
    test_shl_example();
    test_shr_example();
    test_random();
    test_op_a_change();
    test_back_to_back();
    test_reset_mid();
    test_slow_divider();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
